// File: rtl/cpu_pkg.sv
// Shared CPU constants and the program-loader state encoding.
// The CPU top and the loader both take their widths from here.
package cpu_pkg;
  localparam int DATA_W     = 4;
  localparam int REG_COUNT  = 3;
  localparam int INST_DEPTH = 16;
  localparam int INST_W     = 2 * DATA_W;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    LOAD_REG     = 3'd1,
    LOAD_INST_HI = 3'd2,
    LOAD_INST_LO = 3'd3,
    DONE         = 3'd4,
    ERR          = 3'd5
  } ld_state_e;
endpackage

// File: rtl/nibble_packer.sv
// Pairs two stream nibbles into one instruction word.
// Ports:
//   clk, rst   clock, async active-high reset
//   hi_ld_i    accept nib_i as the high half
//   lo_ld_i    accept nib_i as the low half; word goes out next cycle
//   nib_i      stream nibble
//   word_o     registered {hi, lo}; holds between pairs
//   vld_o      one-cycle pulse, aligned with a fresh word_o
module nibble_packer #(
  parameter  int DATA_W = 4,
  localparam int W      = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_ld_i,
  input  logic              lo_ld_i,
  input  logic [DATA_W-1:0] nib_i,
  output logic [W-1:0]      word_o,
  output logic              vld_o
);
  logic [DATA_W-1:0] hi_q;
  logic [W-1:0]      word_q;
  logic              vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= lo_ld_i;
      if (hi_ld_i) hi_q   <= nib_i;
      if (lo_ld_i) word_q <= {hi_q, nib_i};
    end
  end

  assign word_o = word_q;
  assign vld_o  = vld_q;
endmodule

// File: rtl/prog_loader.sv
// Program loader: takes a nibble stream and fills the register file with the
// first REG_COUNT nibbles, then packs the rest in pairs into instruction words
// written at ascending instruction-memory addresses.
// Ports:
//   clk, rst                    clock, async active-high reset
//   start                       begin a load (only from IDLE/DONE/ERR)
//   in_valid/in_ready           stream handshake; in_data nibble, in_last end mark
//   reg_wr_en/addr/wr_data      register file write port (registered)
//   inst_wr_en/addr/wr_data     instruction memory write port (registered)
//   inst_count                  instructions written so far in this load
//   load_done/load_err          completion / abort levels
module prog_loader #(
  parameter  int DATA_W     = cpu_pkg::DATA_W,
  parameter  int REG_COUNT  = cpu_pkg::REG_COUNT,
  parameter  int INST_DEPTH = cpu_pkg::INST_DEPTH,
  localparam int INST_W     = 2 * DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_last,
  output logic                          reg_wr_en,
  output logic [$clog2(REG_COUNT)-1:0]  reg_addr,
  output logic [DATA_W-1:0]             reg_wr_data,
  output logic                          inst_wr_en,
  output logic [$clog2(INST_DEPTH)-1:0] inst_addr,
  output logic [INST_W-1:0]             inst_wr_data,
  output logic [$clog2(INST_DEPTH):0]   inst_count,
  output logic                          load_done,
  output logic                          load_err
);
  import cpu_pkg::*;

  localparam int RA_W = $clog2(REG_COUNT);
  localparam int IA_W = $clog2(INST_DEPTH);

  ld_state_e         state_q, state_d;
  logic [RA_W-1:0]   reg_ptr_q, reg_ptr_d;
  logic [IA_W:0]     cnt_q, cnt_d;       // low bits double as the write pointer
  logic              reg_wr_en_q;
  logic [RA_W-1:0]   reg_addr_q;
  logic [DATA_W-1:0] reg_wr_data_q;
  logic [IA_W-1:0]   inst_addr_q;

  logic hs, hs_reg, hs_hi, hs_lo;

  // Ready is a pure decode of the state register, never of in_valid.
  assign in_ready = (state_q == LOAD_REG) || (state_q == LOAD_INST_HI) ||
                    (state_q == LOAD_INST_LO);
  assign hs     = in_valid && in_ready;
  assign hs_reg = hs && (state_q == LOAD_REG);
  assign hs_hi  = hs && (state_q == LOAD_INST_HI);
  assign hs_lo  = hs && (state_q == LOAD_INST_LO);

  always_comb begin
    state_d   = state_q;
    reg_ptr_d = reg_ptr_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d   = LOAD_REG;
          reg_ptr_d = '0;
          cnt_d     = '0;
        end
      end
      LOAD_REG: begin
        if (hs) begin
          reg_ptr_d = reg_ptr_q + RA_W'(1);
          if (in_last)                                 state_d = ERR;
          else if (reg_ptr_q == RA_W'(REG_COUNT - 1))  state_d = LOAD_INST_HI;
        end
      end
      LOAD_INST_HI: begin
        if (hs) state_d = in_last ? ERR : LOAD_INST_LO;
      end
      LOAD_INST_LO: begin
        if (hs) begin
          cnt_d = cnt_q + (IA_W+1)'(1);
          // in_last wins over overflow: a full-depth program ends cleanly.
          if (in_last)                                     state_d = DONE;
          else if (cnt_q == (IA_W+1)'(INST_DEPTH - 1))     state_d = ERR;
          else                                             state_d = LOAD_INST_HI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      reg_ptr_q     <= '0;
      cnt_q         <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      inst_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      reg_ptr_q   <= reg_ptr_d;
      cnt_q       <= cnt_d;
      reg_wr_en_q <= hs_reg;
      if (hs_reg) begin
        reg_addr_q    <= reg_ptr_q;
        reg_wr_data_q <= in_data;
      end
      if (hs_lo) inst_addr_q <= cnt_q[IA_W-1:0];
    end
  end

  nibble_packer #(.DATA_W(DATA_W)) u_pack (
    .clk     (clk),
    .rst     (rst),
    .hi_ld_i (hs_hi),
    .lo_ld_i (hs_lo),
    .nib_i   (in_data),
    .word_o  (inst_wr_data),
    .vld_o   (inst_wr_en)
  );

  assign reg_wr_en   = reg_wr_en_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wr_data = reg_wr_data_q;
  assign inst_addr   = inst_addr_q;
  assign inst_count  = cnt_q;
  assign load_done   = (state_q == DONE);
  assign load_err    = (state_q == ERR);
endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_last;
  logic [3:0] in_data;
  logic       in_ready, reg_wr_en, inst_wr_en, load_done, load_err;
  logic [1:0] reg_addr;
  logic [3:0] reg_wr_data, inst_addr;
  logic [7:0] inst_wr_data;
  logic [4:0] inst_count;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .inst_wr_en(inst_wr_en), .inst_addr(inst_addr),
    .inst_wr_data(inst_wr_data), .inst_count(inst_count), .load_done(load_done),
    .load_err(load_err)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] all_out();
    return {in_ready, reg_wr_en, reg_addr, reg_wr_data, inst_wr_en, inst_addr,
            inst_wr_data, inst_count, load_done, load_err};
  endfunction

  // write recorder
  logic [5:0]  rec_reg[$];
  logic [11:0] rec_inst[$];
  int          both_cnt;
  always @(negedge clk) begin
    if (reg_wr_en)  rec_reg.push_back({reg_addr, reg_wr_data});
    if (inst_wr_en) rec_inst.push_back({inst_addr, inst_wr_data});
    if (reg_wr_en && inst_wr_en) both_cnt++;
  end

  // stream under test and reference model results
  logic [3:0]  s_d[$];
  bit          s_l[$];
  logic [5:0]  exp_reg[$];
  logic [11:0] exp_inst[$];

  task automatic clr();
    s_d.delete(); s_l.delete();
  endtask
  task automatic add(input logic [3:0] d, input bit l);
    s_d.push_back(d); s_l.push_back(l);
  endtask

  // Walks the stream by the loader's rules: registers first, then pairs.
  task automatic model(output int acc, output bit dn, output bit er, output int cnt);
    logic [3:0] hi;
    hi = 0; acc = 0; dn = 0; er = 0; cnt = 0;
    exp_reg.delete(); exp_inst.delete();
    for (int i = 0; i < s_d.size(); i++) begin
      acc = i + 1;
      if (i < REG_COUNT) begin
        exp_reg.push_back({2'(i), s_d[i]});
        if (s_l[i]) begin er = 1; break; end
      end else if (((i - REG_COUNT) % 2) == 0) begin
        hi = s_d[i];
        if (s_l[i]) begin er = 1; break; end
      end else begin
        exp_inst.push_back({4'(cnt), hi, s_d[i]});
        cnt++;
        if (s_l[i]) begin dn = 1; break; end
        if (cnt == INST_DEPTH) begin er = 1; break; end
      end
    end
  endtask

  // Enter at a negedge, leave at a negedge.
  task automatic send(input logic [3:0] d, input bit l, input int stall, output bit ok);
    int k;
    for (int s = 0; s < stall; s++) begin
      in_valid = 0; in_data = 4'($urandom); in_last = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1; in_data = d; in_last = l; k = 0;
    while (!in_ready && k < 8) begin @(negedge clk); k++; end
    ok = in_ready;
    if (ok) @(negedge clk);
    in_valid = 0; in_last = 0;
  endtask

  task automatic run_load(input string tag, input int stall, input bit rnd, input int restart_at);
    int acc, eacc, ecnt;
    bit edn, eer, ok;
    rec_reg.delete(); rec_inst.delete(); both_cnt = 0;
    start = 1; @(negedge clk); start = 0;
    acc = 0;
    for (int i = 0; i < s_d.size(); i++) begin
      if (i == restart_at) begin start = 1; @(negedge clk); start = 0; end
      send(s_d[i], s_l[i], rnd ? int'($urandom_range(stall, 0)) : stall, ok);
      if (!ok) break;
      acc++;
    end
    repeat (3) @(negedge clk);
    model(eacc, edn, eer, ecnt);
    chk({tag, " accepted"}, acc, eacc);
    chk({tag, " nreg"}, rec_reg.size(), exp_reg.size());
    for (int i = 0; i < exp_reg.size() && i < rec_reg.size(); i++)
      chk($sformatf("%s reg%0d", tag, i), rec_reg[i], exp_reg[i]);
    chk({tag, " ninst"}, rec_inst.size(), exp_inst.size());
    for (int i = 0; i < exp_inst.size() && i < rec_inst.size(); i++)
      chk($sformatf("%s inst%0d", tag, i), rec_inst[i], exp_inst[i]);
    chk({tag, " inst_count"}, inst_count, ecnt);
    chk({tag, " load_done"}, load_done, edn);
    chk({tag, " load_err"}, load_err, eer);
    chk({tag, " in_ready"}, in_ready, 0);
    chk({tag, " both_strobes"}, both_cnt, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int n, mode;
    rst = 1; start = 0; in_valid = 0; in_data = 0; in_last = 0;
    repeat (2) @(negedge clk);
    chk("reset outputs", all_out(), 0);
    rst = 0;
    @(negedge clk);
    chk("idle outputs", all_out(), 0);

    // nominal
    clr(); add(1,0); add(2,0); add(3,0); add(4'hA,0); add(5,0); add(4'hC,0); add(3,1);
    run_load("nominal", 0, 0, -1);
    chk("nominal inst0 A5", rec_inst.size() > 0 ? rec_inst[0] : 12'hFFF, 12'h0A5);
    chk("nominal inst1 C3", rec_inst.size() > 1 ? rec_inst[1] : 12'hFFF, 12'h1C3);

    // stall: same stream, 3 idle cycles (random junk on data/last) before each nibble
    run_load("stall", 3, 0, -1);

    // short program
    clr(); add(1,0); add(2,1);
    run_load("short", 1, 1, -1);

    // odd nibble count
    clr(); add(4'($urandom),0); add(4'($urandom),0); add(4'($urandom),0);
    add(7,0); add(4'hE,0); add(9,1);
    run_load("odd", 1, 1, -1);

    // exactly INST_DEPTH instructions, in_last on the final nibble
    clr();
    for (int i = 0; i < REG_COUNT + 2*INST_DEPTH; i++)
      add(4'($urandom), i == REG_COUNT + 2*INST_DEPTH - 1);
    run_load("full", 0, 0, -1);
    chk("full count16", inst_count, 16);

    // one nibble too many: overflow after the address-15 write
    clr();
    for (int i = 0; i < REG_COUNT + 2*INST_DEPTH + 1; i++)
      add(4'($urandom), i == REG_COUNT + 2*INST_DEPTH);
    run_load("overflow", 0, 0, -1);
    chk("overflow last addr", rec_inst.size() > 0 ? 32'(rec_inst[rec_inst.size()-1][11:8]) : 32'hFF, 15);

    // start during LOAD_REG must not restart the load
    clr(); add(5,0); add(6,0); add(7,0); add(1,0); add(2,1);
    run_load("start_ign", 0, 0, 2);

    // random programs (restart from DONE/ERR each time)
    for (int t = 0; t < 8; t++) begin
      clr();
      mode = $urandom_range(3, 0);
      if (mode == 0) n = $urandom_range(REG_COUNT, 1);
      else if (mode == 1) n = REG_COUNT + 2*$urandom_range(18, 0) + 1;
      else n = REG_COUNT + 2*$urandom_range(18, 1);
      for (int i = 0; i < n; i++) add(4'($urandom), i == n - 1);
      run_load($sformatf("rand%0d", t), 2, 1, -1);
    end

    // asynchronous reset while waiting for a low nibble
    clr();
    start = 1; @(negedge clk); start = 0;
    send(4'h4, 0, 0, ok); send(4'h6, 0, 0, ok); send(4'h9, 0, 0, ok); send(4'hB, 0, 0, ok);
    @(negedge clk);
    chk("pre_rst reg_addr", reg_addr, 2);
    chk("pre_rst reg_data", reg_wr_data, 4'h9);
    in_valid = 1; in_data = 4'h5; in_last = 0;
    rec_reg.delete(); rec_inst.delete();
    #2 rst = 1;
    #1 chk("async rst outputs", all_out(), 0);
    @(negedge clk); in_valid = 0;
    @(negedge clk); rst = 0;
    repeat (4) @(negedge clk);
    chk("post_rst writes", rec_reg.size() + rec_inst.size(), 0);
    chk("post_rst outputs", all_out(), 0);

    // fresh load after reset starts at register 0
    clr(); add(4'h8,0); add(4'h9,0); add(4'hA,0); add(4'h1,0); add(4'hF,1);
    run_load("after_rst", 0, 0, -1);
    // and again from DONE
    run_load("from_done", 1, 1, -1);
    chk("from_done reg_addr0", rec_reg.size() > 0 ? 32'(rec_reg[0][5:4]) : 32'hFF, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Front-end load stage that sits directly upstream of the CPU core's register file and instruction memory.
- Accepts a nibble stream over a valid/ready handshake and writes the first REG_COUNT nibbles into the input registers.
- Packs the remaining nibbles in pairs into INST_W-bit instructions and writes them to sequential instruction-memory addresses.
- Signals completion or error to the core's phase controller, which leaves the load phase only after load_done.

Parameters:
- DATA_W, 4, width of one stream nibble and of one register word
- REG_COUNT, 3, number of input registers loaded before instructions
- INST_DEPTH, 16, instruction memory depth in words
- INST_W, 2*DATA_W, instruction width; derived, must not be overridden

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- in_valid  input  1  stream word valid
- in_ready  output  1  loader can accept a word
- in_data  input  DATA_W  stream nibble
- in_last  input  1  marks the final nibble of the program
- reg_wr_en  output  1  register file write strobe
- reg_addr  output  $clog2(REG_COUNT)  register write address
- reg_wr_data  output  DATA_W  register write data
- inst_wr_en  output  1  instruction memory write strobe
- inst_addr  output  $clog2(INST_DEPTH)  instruction write address
- inst_wr_data  output  INST_W  instruction write data
- inst_count  output  $clog2(INST_DEPTH)+1  instructions written in the current load
- load_done  output  1  level; high in DONE
- load_err  output  1  level; high in ERR

Behaviour:
- Reset, asynchronous: state=IDLE; every output = 0; internal counters and the nibble holding register cleared.
- A handshake is in_valid && in_ready sampled on a rising clk edge.
- in_ready = 1 only in LOAD_REG and LOAD_INST. It is registered-state based and has no combinational path from in_valid.
- States:
  - IDLE: waiting for start.
  - LOAD_REG: loading input registers.
  - LOAD_INST_HI: awaiting the high nibble of an instruction.
  - LOAD_INST_LO: awaiting the low nibble of an instruction.
  - DONE: load complete.
  - ERR: load aborted.
- IDLE/DONE/ERR + start -> LOAD_REG. Entering LOAD_REG clears reg pointer, inst pointer, inst_count, load_done and load_err.
- LOAD_REG: each handshake writes the nibble to register reg_ptr.
  - reg_wr_en=1, reg_addr=reg_ptr, reg_wr_data=in_data, all registered, one cycle after the handshake.
  - After the REG_COUNT-th nibble -> LOAD_INST_HI.
  - in_last on any register nibble -> ERR (short program). That nibble is still written.
- LOAD_INST_HI: a handshake stores the nibble as bits [INST_W-1:DATA_W] -> LOAD_INST_LO.
  - in_last here -> ERR (odd nibble count). No instruction write occurs.
- LOAD_INST_LO: a handshake forms {hi,in_data}.
  - Next cycle: inst_wr_en=1, inst_addr=inst_ptr, inst_wr_data={hi,in_data}.
  - inst_ptr and inst_count increment in the same cycle.
  - in_last -> DONE.
  - Otherwise, if inst_count reaches INST_DEPTH -> ERR (overflow). The INST_DEPTH-th word is still written, and inst_ptr does not wrap.
  - Otherwise -> LOAD_INST_HI.
- Write strobes are high for exactly one cycle per write. reg_wr_en and inst_wr_en are never high together.
- Addresses and data hold their last value when the strobe is low.
- start outside IDLE/DONE/ERR is ignored. A load in progress is not restarted.
- A program of exactly INST_DEPTH instructions with in_last on its final nibble -> DONE, not ERR.
- DONE and ERR hold until start or rst. in_ready=0 in both states.
- rst mid-load aborts immediately with no further writes. The contents of downstream memories are not this block's concern.
- in_data and in_last are ignored when no handshake occurs. in_valid may stall arbitrarily between nibbles.

Decomposition:
- Package cpu_pkg holds:
  - the loader state enum: IDLE, LOAD_REG, LOAD_INST_HI, LOAD_INST_LO, DONE, ERR;
  - constants DATA_W=4, REG_COUNT=3, INST_DEPTH=16, INST_W=8.
  - The CPU top uses the same constants.
- One sub-module is natural: nibble_packer. It holds the high-nibble register and emits the packed word plus a valid pulse.
- The FSM, pointers and write-port registers stay in prog_loader.

Test Plan:
- Nominal load:
  - Stimulus: start, then nibbles 1,2,3, then A,5,C,3 with in_last on 3.
  - Required: register writes at addresses 0/1/2 with data 1/2/3; instruction writes at address 0 = 0xA5 and address 1 = 0xC3.
  - Required: inst_count=2, load_done=1 the cycle after the last write, in_ready=0 afterwards.
- Stall and backpressure: same stream with in_valid deasserted for 3 random cycles between nibbles -> identical writes and count; no write strobe while stalled.
- Short program: start, then 1,2 with in_last on 2 -> register writes at addresses 0 and 1 only, load_err=1, inst_wr_en never asserted.
- Odd nibble: 3 register nibbles, then 7,E,9 with in_last on 9 -> 0x7E written at address 0, then load_err=1, inst_count=1.
- Overflow boundary:
  - Stimulus: 32 instruction nibbles with in_last on the 32nd -> DONE with inst_count=16, final write at address 15.
  - Rerun with a 33rd nibble and no in_last on the 32nd -> ERR after the address-15 write, in_ready=0.
- Reset and restart:
  - Stimulus: assert rst asynchronously mid LOAD_INST_LO.
  - Required: all outputs go to 0 without waiting for a clock edge, and no write follows.
  - Then: start during LOAD_REG is ignored; start from DONE restarts with reg_addr=0.
